// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-strobed keypad scan with per-key debounce, key bitmap and press/release event FIFO
module keypad_matrix_scanner #(
    parameter int ROWS_N         = 4,
    parameter int COLS_N         = 4,
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int K             = ROWS_N * COLS_N,
    localparam int KW            = (K > 1) ? $clog2(K) : 1
) (
    input  logic              CLK_25MHZ,
    input  logic              RESET_N,
    output logic [ROWS_N-1:0] ROW_DRIVE,
    input  logic [COLS_N-1:0] COLS,
    output logic [K-1:0]      KEYS,
    output logic              ANY_KEY,
    output logic              EVENT_VALID,
    input  logic              EVENT_READY,
    output logic [KW-1:0]     EVENT_KEY,
    output logic              EVENT_PRESS,
    output logic              OVERFLOW
);
    localparam int RW  = (ROWS_N > 1) ? $clog2(ROWS_N) : 1;
    localparam int CLW = (COLS_N > 1) ? $clog2(COLS_N) : 1;
    localparam int SW  = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SETTLE, SAMPLE, UPDATE} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     div;
    logic [RW-1:0]     row;
    logic [CLW-1:0]    col;
    logic [COLS_N-1:0] sync1, sync2, col_lat;
    logic [DW-1:0]     cnt [K];
    logic [K-1:0]      keys, keys_nx;
    logic              any_q;
    logic [KW-1:0]     k;
    logic              differ, ripe, full, push, pop, last_col, last_row;
    logic [KW-1:0]     fifo_key [FIFO_DEPTH];
    logic              fifo_press [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    assign k        = KW'(int'(row) * COLS_N + int'(col));
    assign last_col = col == CLW'(COLS_N - 1);
    assign last_row = row == RW'(ROWS_N - 1);
    assign differ   = (state == UPDATE) && (col_lat[col] != keys[k]);
    assign ripe     = int'(cnt[k]) + 1 >= DEBOUNCE_SCANS;
    assign full     = count == (PW+1)'(FIFO_DEPTH);
    assign push     = differ && ripe && !full;
    assign pop      = (count != '0) && EVENT_READY;

    assign ROW_DRIVE   = ~(ROWS_N'(1) << row);
    assign KEYS        = keys;
    assign ANY_KEY     = any_q;
    assign EVENT_VALID = count != '0;
    assign EVENT_KEY   = fifo_key[rd_ptr];
    assign EVENT_PRESS = fifo_press[rd_ptr];

    // key bitmap after this cycle's flip, shared by KEYS and ANY_KEY so both update together
    always_comb begin
        keys_nx = keys;
        if (push) keys_nx[k] = ~keys[k];
    end

    // scan sequencing: settle the driven row, take one snapshot, then walk the columns
    always_comb begin
        state_nx = state == SETTLE ? (div == SW'(SCAN_DIV - 1) ? SAMPLE : SETTLE) :
                   state == SAMPLE ? UPDATE :
                   (last_col ? SETTLE : UPDATE);
    end

    // state register
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) state <= SETTLE;
        else          state <= state_nx;
    end

    // settle divider, row/column pointers, column synchroniser and per-row snapshot
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            div     <= '0;
            row     <= '0;
            col     <= '0;
            sync1   <= '1;
            sync2   <= '1;
            col_lat <= '0;
        end else begin
            sync1   <= COLS;
            sync2   <= sync1;
            div     <= (state == SETTLE && state_nx == SETTLE) ? div + 1'b1 : '0;
            col     <= (state == UPDATE && !last_col) ? col + 1'b1 : '0;
            col_lat <= state == SAMPLE ? ~sync2 : col_lat;
            if (state == UPDATE && last_col) row <= last_row ? '0 : row + 1'b1;
        end
    end

    // debounce counters and stable key state; a ripe flip waits at DEBOUNCE_SCANS-1 while the FIFO is full
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < K; i++) cnt[i] <= '0;
            keys     <= '0;
            any_q    <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (state == UPDATE)
                cnt[k] <= (differ && !ripe) ? cnt[k] + 1'b1 : (differ && !push) ? cnt[k] : '0;
            keys     <= keys_nx;
            any_q    <= |keys_nx;
            OVERFLOW <= OVERFLOW | (differ && ripe && full);
        end
    end

    // event FIFO; fullness is judged before any same-cycle pop
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_key[i]   <= '0;
                fifo_press[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_key[wr_ptr]   <= k;
                fifo_press[wr_ptr] <= ~keys[k];
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed checks of scan timing, debounce, event FIFO backpressure and async reset
module tb_keypad_matrix_scanner;
    localparam int ROWS_N = 4;
    localparam int COLS_N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_drive;
    logic [3:0]  cols;
    logic [15:0] keys;
    logic        any_key;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_key;
    logic        ev_press;
    logic        overflow;
    logic [15:0] pressed;
    int          vectors = 0;
    int          miscompares = 0;

    keypad_matrix_scanner #(
        .ROWS_N(ROWS_N), .COLS_N(COLS_N), .SCAN_DIV(8), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(2)
    ) dut (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .ROW_DRIVE(row_drive), .COLS(cols),
        .KEYS(keys), .ANY_KEY(any_key), .EVENT_VALID(ev_valid), .EVENT_READY(ev_ready),
        .EVENT_KEY(ev_key), .EVENT_PRESS(ev_press), .OVERFLOW(overflow)
    );

    always #5 clk = ~clk;

    // keypad model: a held key shorts its column low while its row is strobed
    always_comb begin
        cols = '1;
        for (int r = 0; r < ROWS_N; r++)
            for (int c = 0; c < COLS_N; c++)
                if (pressed[r*COLS_N+c] && !row_drive[r]) cols[c] = 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; pressed = '0; ev_ready = 1'b0;
        // reset state and row stepping
        step(2);
        check("rst_keys", 32'(keys), 0);
        check("rst_any", 32'(any_key), 0);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_rowdrv", 32'(row_drive), 32'hE);
        check("rst_evkey", 32'(ev_key), 0);
        check("rst_evpress", 32'(ev_press), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        step(12); check("row0_end", 32'(row_drive), 32'hE);
        step(1);  check("row1", 32'(row_drive), 32'hD);
        step(13); check("row2", 32'(row_drive), 32'hB);
        step(13); check("row3", 32'(row_drive), 32'h7);
        step(13); check("row0_wrap", 32'(row_drive), 32'hE);
        // key 9 press and release, three scans each
        ev_ready = 1'b1; pressed = 16'h0200;
        step(140); check("k9_pre_keys", 32'(keys), 0);
        check("k9_pre_valid", 32'(ev_valid), 0);
        step(1);
        check("k9_keys", 32'(keys), 32'h0200);
        check("k9_any", 32'(any_key), 1);
        check("k9_valid", 32'(ev_valid), 1);
        check("k9_evkey", 32'(ev_key), 9);
        check("k9_press", 32'(ev_press), 1);
        step(1); check("k9_popped", 32'(ev_valid), 0);
        pressed = '0;
        step(154); check("k9r_pre_keys", 32'(keys), 32'h0200);
        step(1);
        check("k9r_keys", 32'(keys), 0);
        check("k9r_any", 32'(any_key), 0);
        check("k9r_valid", 32'(ev_valid), 1);
        check("k9r_evkey", 32'(ev_key), 9);
        check("k9r_press", 32'(ev_press), 0);
        step(1); check("k9r_popped", 32'(ev_valid), 0);
        // bounce: two scans pressed, then released; counter must fall back to zero
        pressed = 16'h0200;
        step(52); check("b_scan1", 32'(keys), 0);
        step(52); check("b_scan2", 32'(keys), 0);
        pressed = '0;
        step(52); check("b_rel", 32'(keys), 0);
        check("b_valid", 32'(ev_valid), 0);
        pressed = 16'h0200;
        step(52); check("b_cnt_cleared", 32'(keys), 0);
        check("b_cnt_valid", 32'(ev_valid), 0);
        pressed = '0;
        step(52); check("b_end", 32'(keys), 0);
        // backpressure: keys 0, 5, 10 with READY low and a two-entry FIFO
        ev_ready = 1'b0; pressed = 16'h0421;
        step(128);
        check("bp_k0_keys", 32'(keys), 32'h0001);
        check("bp_k0_valid", 32'(ev_valid), 1);
        check("bp_k0_evkey", 32'(ev_key), 0);
        check("bp_k0_ovf", 32'(overflow), 0);
        step(14);
        check("bp_k5_keys", 32'(keys), 32'h0021);
        check("bp_k5_head", 32'(ev_key), 0);
        step(14);
        check("bp_k10_keys", 32'(keys), 32'h0021);
        check("bp_ovf", 32'(overflow), 1);
        check("bp_stable_key", 32'(ev_key), 0);
        check("bp_stable_press", 32'(ev_press), 1);
        check("bp_stable_valid", 32'(ev_valid), 1);
        ev_ready = 1'b1;
        step(1);
        check("bp_drain5_valid", 32'(ev_valid), 1);
        check("bp_drain5_key", 32'(ev_key), 5);
        check("bp_drain5_press", 32'(ev_press), 1);
        step(1); check("bp_empty", 32'(ev_valid), 0);
        step(49); check("bp_retry_pre", 32'(keys), 32'h0021);
        step(1);
        check("bp_retry_keys", 32'(keys), 32'h0421);
        check("bp_retry_valid", 32'(ev_valid), 1);
        check("bp_retry_key", 32'(ev_key), 10);
        check("bp_ovf_sticky", 32'(overflow), 1);
        step(1); check("bp_retry_popped", 32'(ev_valid), 0);
        pressed = '0;
        step(156);
        check("bp_released", 32'(keys), 0);
        check("bp_rel_valid", 32'(ev_valid), 0);
        // same row: keys 4 and 7 flip three cycles apart
        pressed = 16'h0090;
        step(140);
        check("sr_k4_keys", 32'(keys), 32'h0010);
        check("sr_k4_key", 32'(ev_key), 4);
        check("sr_k4_valid", 32'(ev_valid), 1);
        step(1); check("sr_gap", 32'(ev_valid), 0);
        step(2);
        check("sr_k7_keys", 32'(keys), 32'h0090);
        check("sr_k7_key", 32'(ev_key), 7);
        check("sr_k7_valid", 32'(ev_valid), 1);
        step(1); check("sr_k7_popped", 32'(ev_valid), 0);
        // asynchronous reset with an event pending
        ev_ready = 1'b0; pressed = 16'h0290;
        step(114);
        check("ar_pre_keys", 32'(keys), 32'h0290);
        check("ar_pre_valid", 32'(ev_valid), 1);
        check("ar_pre_key", 32'(ev_key), 9);
        rst_n = 1'b0;
        #1;
        check("ar_keys", 32'(keys), 0);
        check("ar_any", 32'(any_key), 0);
        check("ar_valid", 32'(ev_valid), 0);
        check("ar_ovf", 32'(overflow), 0);
        check("ar_rowdrv", 32'(row_drive), 32'hE);
        pressed = 16'h0200; ev_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(13); check("ar_row1", 32'(row_drive), 32'hD);
        step(127); check("ar_k9_pre", 32'(keys), 0);
        step(1);
        check("ar_k9_keys", 32'(keys), 32'h0200);
        check("ar_k9_valid", 32'(ev_valid), 1);
        check("ar_k9_key", 32'(ev_key), 9);
        check("ar_k9_press", 32'(ev_press), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised keypad matrix scanner for the board-level PMOD keypad. It drives one row at a time, synchronises and samples the column lines, and debounces every key with a per-key counter. It publishes a stable key bitmap plus a FIFO of press/release events with a valid/ready handshake. It sits between the PMOD ROWS/COLS pins and the core in the 25 MHz domain, generalising the fixed 4x4 direct hookup.

Parameters:
ROWS_N, 4, number of matrix rows (>=1)
COLS_N, 4, number of matrix columns (>=1)
SCAN_DIV, 25000, settle cycles per row before sampling (>=4; 1 ms at 25 MHz)
DEBOUNCE_SCANS, 4, consecutive differing scans required to flip a key (>=1)
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
CLK_25MHZ  in  1  single clock for all logic
RESET_N  in  1  asynchronous, active-low reset
ROW_DRIVE  out  ROWS_N  active-low one-hot row strobe; top level converts to open-drain
COLS  in  COLS_N  raw column lines, active-low (pulled up off-board), asynchronous
KEYS  out  ROWS_N*COLS_N  debounced state, bit k=1 means pressed, k = row*COLS_N + col
ANY_KEY  out  1  OR of KEYS
EVENT_VALID  out  1  FIFO non-empty
EVENT_READY  in  1  consumer accepts head event
EVENT_KEY  out  clog2(ROWS_N*COLS_N) (min 1)  key index of head event
EVENT_PRESS  out  1  1 = press, 0 = release
OVERFLOW  out  1  sticky: an event was deferred because the FIFO was full

Behaviour:
- Reset (async, RESET_N=0): state SETTLE, row=0, ROW_DRIVE=~1 (row 0 low), KEYS=0, ANY_KEY=0, all debounce counters 0, FIFO empty, EVENT_VALID=0, EVENT_KEY=0, EVENT_PRESS=0, OVERFLOW=0, synchroniser flops = all ones. Applies immediately mid-operation; in-flight events are discarded.
- COLS passes through a 2-flop synchroniser; raw = ~synced (1 = pressed).
- FSM per row:
  SETTLE: count SCAN_DIV cycles, then go to SAMPLE.
  SAMPLE: 1 cycle; latch raw column vector; go to UPDATE with col=0.
  UPDATE: 1 cycle per column, COLS_N cycles total. For key k=row*COLS_N+col:
  - raw==KEYS[k]: counter <= 0.
  - Otherwise, counter+1 < DEBOUNCE_SCANS: counter increments.
  - Otherwise (counter+1 reached DEBOUNCE_SCANS): if the FIFO is not full, flip KEYS[k], push {k, new state}, counter <= 0. If the FIFO is full, no flip, counter holds at DEBOUNCE_SCANS-1 (retried next scan), OVERFLOW <= 1.
  - After the last column: row <= (row==ROWS_N-1) ? 0 : row+1; ROW_DRIVE updates on the same edge; go to SETTLE.
- Row period = SCAN_DIV+1+COLS_N cycles; frame = ROWS_N times that.
- Counter width = clog2(DEBOUNCE_SCANS+1). Counters never exceed DEBOUNCE_SCANS-1.
- Latency: a push in an UPDATE cycle gives EVENT_VALID=1 on the next cycle. Events are emitted in scan order: row-major, ascending column.
- FIFO: EVENT_* present the registered head entry. Pop occurs when EVENT_VALID && EVENT_READY.
  - Simultaneous push and pop when not full: count unchanged.
  - "Full" is evaluated before the same-cycle pop, so a full FIFO with a concurrent pop still refuses the push.
  - Pointers wrap modulo FIFO_DEPTH.
  - EVENT_* stay stable while VALID && !READY.
- KEYS never disagrees with the pushed event stream: every KEYS flip has exactly one event, and no event is lost.
- OVERFLOW clears only on reset.
- ANY_KEY is registered alongside KEYS (same cycle).

Test Plan:
(Bench parameters: ROWS_N=4, COLS_N=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=2; row period 13 cycles, frame 52 cycles.)
1. Reset, COLS=4'b1111 -> KEYS=0, EVENT_VALID=0, ROW_DRIVE=1110. ROW_DRIVE then steps 1101, 1011, 0111, 1110 every 13 cycles.
2. Pull COLS[1] low while ROW_DRIVE[2]=0, held for 3 frames, READY=1 -> KEYS[9]=1 and ANY_KEY=1 after the 3rd row-2 UPDATE. One event {key 9, press 1}. Releasing for 3 frames -> {9, 0}, KEYS=0.
3. Bounce: key 9 pressed for 2 frames then released -> no event, KEYS[9] stays 0, counter back to 0.
4. Backpressure, READY=0: keys 0, 5, 10 held -> FIFO holds {0,1},{5,1}; KEYS[10]=0; OVERFLOW=1. READY=1 -> events drain 0, 5. On the next row-2 scan, {10,1} is emitted and KEYS[10]=1.
5. Same row: keys 4 and 7 (row 1, cols 0 and 3) held, READY=1 -> events 4 then 7, pushed 3 cycles apart in one UPDATE pass.
6. RESET_N low asynchronously while KEYS[9]=1 and EVENT_VALID=1 -> immediately KEYS=0, EVENT_VALID=0, OVERFLOW=0, ROW_DRIVE=1110. Scanning restarts cleanly after release.
